// File: rtl/para_stream_feeder_layer7.sv
// para_stream_feeder_layer7: byte-stream to parameter-word feeder for layer 7.
// Assembles big-endian `PARA_WIDTH words from an 8-bit valid/ready stream and
// strobes them into the layer-7 parameter loader, FM_DEPTH + 5*CHANNEL_NUM
// words per load session.
// Optional feature: define PARA_CHECKSUM_EN to receive one trailing checksum
// word per session (sum of all words, mod 2^`PARA_WIDTH) and flag a mismatch
// on chk_err.

`ifndef PARA_WIDTH
`define PARA_WIDTH 16
`endif
`ifndef LOAD_PARA
`define LOAD_PARA 1'b0
`endif

module para_stream_feeder_layer7 #(
    parameter int FM_DEPTH    = 256,
    parameter int CHANNEL_NUM = 512,
    parameter int LOG2TOTAL   = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode,
    input  logic                          start,
    input  logic                          s_valid,
    input  logic [7:0]                    s_data,
    output logic                          s_ready,
    output logic                          data_e_para,
    output logic signed [`PARA_WIDTH-1:0] para_in,
    output logic                          busy,
    output logic                          load_done,
    output logic                          err_abort,
    output logic                          chk_err
);

    // `PARA_WIDTH must be a multiple of 8.
    localparam int PW    = `PARA_WIDTH;
    localparam int BPW   = PW / 8;
    localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TOTAL = FM_DEPTH + 5 * CHANNEL_NUM;

    localparam logic [BCW-1:0]       LAST_BYTE = BCW'(BPW - 1);
    localparam logic [LOG2TOTAL-1:0] LAST_WORD = LOG2TOTAL'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
`ifdef PARA_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [LOG2TOTAL-1:0]   word_cnt_q, word_cnt_d;
    logic [PW-1:0]          shift_q, shift_d;
    logic [PW-1:0]          para_q, para_d;
    logic                   strobe_q, strobe_d;
    logic                   s_ready_q, s_ready_d;
    logic                   err_abort_q, err_abort_d;
`ifdef PARA_CHECKSUM_EN
    logic [PW-1:0]          sum_q, sum_d;
    logic                   chk_err_q, chk_err_d;
`endif

    logic          load_mode;
    logic          accept;
    logic          last_byte;
    logic [PW-1:0] assembled;

    assign load_mode = (mode == `LOAD_PARA);
    assign accept    = s_valid && s_ready_q;
    assign last_byte = (byte_cnt_q == LAST_BYTE);
    // Earlier bytes shift toward the MSB, so the first byte lands on top.
    assign assembled = (shift_q << 8) | PW'(s_data);

    // State register and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them update from the
        // same pre-edge values; blocking = would create order-dependent races.
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            shift_q     <= '0;
            para_q      <= '0;
            strobe_q    <= 1'b0;
            s_ready_q   <= 1'b0;
            err_abort_q <= 1'b0;
`ifdef PARA_CHECKSUM_EN
            sum_q       <= '0;
            chk_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            shift_q     <= shift_d;
            para_q      <= para_d;
            strobe_q    <= strobe_d;
            s_ready_q   <= s_ready_d;
            err_abort_q <= err_abort_d;
`ifdef PARA_CHECKSUM_EN
            sum_q       <= sum_d;
            chk_err_q   <= chk_err_d;
`endif
        end
    end

    // Next-state logic: session control, byte assembly and word strobes.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves one unassigned and infers a latch.
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        shift_d     = shift_q;
        para_d      = para_q;
        strobe_d    = 1'b0;
        err_abort_d = err_abort_q;
`ifdef PARA_CHECKSUM_EN
        sum_d       = sum_q;
        chk_err_d   = chk_err_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (start && load_mode) begin
                    state_d     = RECV;
                    byte_cnt_d  = '0;
                    word_cnt_d  = '0;
                    shift_d     = '0;
                    err_abort_d = 1'b0;
`ifdef PARA_CHECKSUM_EN
                    sum_d       = '0;
                    chk_err_d   = 1'b0;
`endif
                end else if (state_q == DONE && !load_mode) begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (!load_mode) begin
                    // Abort: drop the partial word and return to IDLE.
                    state_d     = IDLE;
                    byte_cnt_d  = '0;
                    err_abort_d = 1'b1;
                end else if (accept) begin
                    if (last_byte) begin
                        byte_cnt_d = '0;
                        para_d     = assembled;
                        strobe_d   = 1'b1;
                        word_cnt_d = word_cnt_q + LOG2TOTAL'(1);
`ifdef PARA_CHECKSUM_EN
                        sum_d      = sum_q + assembled;
                        if (word_cnt_q == LAST_WORD) state_d = CHK;
`else
                        if (word_cnt_q == LAST_WORD) state_d = DONE;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        shift_d    = assembled;
                    end
                end
            end
`ifdef PARA_CHECKSUM_EN
            CHK: begin
                if (!load_mode) begin
                    state_d     = IDLE;
                    byte_cnt_d  = '0;
                    err_abort_d = 1'b1;
                end else if (accept) begin
                    if (last_byte) begin
                        // Checksum word is compared, never forwarded.
                        byte_cnt_d = '0;
                        chk_err_d  = (assembled != sum_q);
                        state_d    = DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        shift_d    = assembled;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

`ifdef PARA_CHECKSUM_EN
        s_ready_d = (state_d == RECV) || (state_d == CHK);
`else
        s_ready_d = (state_d == RECV);
`endif
    end

    // A strobe still pending when mode rises is suppressed at the output.
    assign data_e_para = strobe_q && load_mode;
    assign para_in     = para_q;
    assign s_ready     = s_ready_q;
    assign busy        = (state_q == RECV);
    assign load_done   = (state_q == DONE);
    assign err_abort   = err_abort_q;
`ifdef PARA_CHECKSUM_EN
    assign chk_err     = chk_err_q;
`else
    assign chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_para_stream_feeder_layer7.sv
// Bench for para_stream_feeder_layer7: random byte streams with random valid
// gaps, compared against a word list computed directly from the byte stream.

`ifndef PARA_WIDTH
`define PARA_WIDTH 16
`endif

module tb_para_stream_feeder_layer7;

    localparam int PW          = `PARA_WIDTH;
    localparam int BPW         = PW / 8;
    localparam int FM_DEPTH    = 256;
    localparam int CHANNEL_NUM = 512;
    localparam int TOTAL       = FM_DEPTH + 5 * CHANNEL_NUM;
    localparam int NBYTES      = TOTAL * BPW;
`ifdef PARA_CHECKSUM_EN
    localparam int XBYTES      = BPW;
`else
    localparam int XBYTES      = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 mode = 1'b1;
    logic                 start = 1'b0;
    logic                 s_valid = 1'b0;
    logic [7:0]           s_data = 8'h00;
    logic                 s_ready;
    logic                 data_e_para;
    logic signed [PW-1:0] para_in;
    logic                 busy;
    logic                 load_done;
    logic                 err_abort;
    logic                 chk_err;

    para_stream_feeder_layer7 #(
        .FM_DEPTH    (FM_DEPTH),
        .CHANNEL_NUM (CHANNEL_NUM),
        .LOG2TOTAL   (12)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .start       (start),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .data_e_para (data_e_para),
        .para_in     (para_in),
        .busy        (busy),
        .load_done   (load_done),
        .err_abort   (err_abort),
        .chk_err     (chk_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    stream [0:NBYTES+BPW-1];
    logic [PW-1:0] exp_w  [0:TOTAL-1];
    logic [PW-1:0] got_q  [$];
    int            strobe_mode_hi = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record every parameter strobe, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (data_e_para === 1'b1) begin
            got_q.push_back(PW'($unsigned(para_in)));
            if (mode) strobe_mode_hi++;
        end
    end

    // Reference: word w is bytes w*BPW.. read big-endian.
    task automatic fill_stream();
        for (int i = 0; i < NBYTES; i++) stream[i] = 8'($urandom);
        stream[0] = 8'h12;
        if (BPW > 1) stream[1] = 8'h34;
        for (int w = 0; w < TOTAL; w++) begin
            logic [PW-1:0] acc;
            acc = '0;
            for (int b = 0; b < BPW; b++) acc = PW'(acc * 256 + stream[w*BPW + b]);
            exp_w[w] = acc;
        end
    endtask

    task automatic set_checksum(input bit off_by_one);
        logic [PW-1:0] sum;
        sum = '0;
        for (int w = 0; w < TOTAL; w++) sum = sum + exp_w[w];
        if (off_by_one) sum = sum + PW'(1);
        for (int b = 0; b < BPW; b++) stream[NBYTES + b] = 8'(sum >> (8 * (BPW - 1 - b)));
    endtask

    function automatic int word_errors(input int n);
        int errs = 0;
        for (int i = 0; i < n; i++)
            if (i >= got_q.size() || got_q[i] !== exp_w[i]) errs++;
        return errs;
    endfunction

    task automatic pulse_start(input logic mode_val);
        @(negedge clk);
        start = 1'b1;
        mode  = mode_val;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer bytes stream[0..n-1] with random 0..max_gap idle cycles between
    // accepted bytes. Returns at a negedge with s_valid low.
    task automatic send_bytes(input int n, input int max_gap);
        int  sent  = 0;
        int  gap   = 0;
        int  guard = 0;
        bit  acc   = 1'b0;
        while (1) begin
            @(negedge clk);
            if (acc) begin
                sent++;
                gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            end
            if (sent >= n) break;
            if (guard > 8 * n + 100) begin
                check("send_timeout", 64'(sent), 64'(n));
                break;
            end
            if (gap > 0) begin
                s_valid = 1'b0;
                gap--;
            end else begin
                s_valid = 1'b1;
                s_data  = stream[sent];
            end
            acc = s_valid && s_ready;
            guard++;
        end
        s_valid = 1'b0;
    endtask

    task automatic run_session(input string tag, input int max_gap, input bit bad_sum);
        logic exp_chk;
`ifdef PARA_CHECKSUM_EN
        exp_chk = bad_sum;
`else
        exp_chk = 1'b0;
`endif
        set_checksum(bad_sum);
        got_q.delete();
        pulse_start(1'b0);
        send_bytes(NBYTES + XBYTES, max_gap);
        repeat (3) @(negedge clk);
        check({tag, "_count"}, 64'(got_q.size()), 64'(TOTAL));
        check({tag, "_words"}, 64'(word_errors(TOTAL)), 64'd0);
        check({tag, "_first"}, (got_q.size() > 0) ? 64'(got_q[0]) : 64'hdead, 64'(exp_w[0]));
        check({tag, "_load_done"}, 64'(load_done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_err_abort"}, 64'(err_abort), 64'd0);
        check({tag, "_chk_err"}, 64'(chk_err), 64'(exp_chk));
    endtask

    initial begin
        fill_stream();

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_strobe", 64'(data_e_para), 64'd0);
        check("rst_para_in", 64'($unsigned(para_in)), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_err_abort", 64'(err_abort), 64'd0);
        check("rst_chk_err", 64'(chk_err), 64'd0);
        rst_n = 1'b1;

        // start with mode HIGH is ignored.
        pulse_start(1'b1);
        repeat (2) @(negedge clk);
        check("calc_start_busy", 64'(busy), 64'd0);
        check("calc_start_s_ready", 64'(s_ready), 64'd0);

        // Back-to-back bytes, then the same stream with random gaps.
        run_session("full", 0, 1'b0);
        run_session("gapped", 5, 1'b1);

        // Abort after 301 bytes: 150 complete words, partial word dropped.
        got_q.delete();
        pulse_start(1'b0);
        send_bytes(301, 2);
        mode = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_count", 64'(got_q.size()), 64'(301 / BPW));
        check("abort_words", 64'(word_errors(301 / BPW)), 64'd0);
        check("abort_err_abort", 64'(err_abort), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_s_ready", 64'(s_ready), 64'd0);
        check("abort_load_done", 64'(load_done), 64'd0);
        pulse_start(1'b0);
        check("restart_err_abort", 64'(err_abort), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);

        // Reset in the middle of word 1000.
        got_q.delete();
        send_bytes(1000 * BPW + 1, 0);
        check("midrst_pre_count", 64'(got_q.size()), 64'd1000);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_s_ready", 64'(s_ready), 64'd0);
        check("midrst_strobe", 64'(data_e_para), 64'd0);
        check("midrst_para_in", 64'($unsigned(para_in)), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_load_done", 64'(load_done), 64'd0);
        check("midrst_err_abort", 64'(err_abort), 64'd0);
        check("midrst_chk_err", 64'(chk_err), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b1;
        repeat (20) @(negedge clk);
        s_valid = 1'b0;
        check("midrst_post_count", 64'(got_q.size()), 64'd1000);
        check("midrst_post_s_ready", 64'(s_ready), 64'd0);

        check("strobe_while_mode_high", 64'(strobe_mode_hi), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/para_stream_feeder_layer7.md
PARA_STREAM_FEEDER_LAYER7 -- requirements
Module: para_stream_feeder_layer7

Interface
REQ-001 SHALL have parameter FM_DEPTH, default 256, RSign parameter count loaded first.
REQ-002 SHALL have parameter CHANNEL_NUM, default 512, per-channel count for each of the 5 BN/RPReLU parameter sets.
REQ-003 SHALL have parameter LOG2TOTAL, default 12, word-counter width, covering TOTAL = FM_DEPTH + 5*CHANNEL_NUM (2816 at defaults).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port mode, input, 1, LOW = `LOAD_PARA (load), HIGH = calculate.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that begins a load session.
REQ-008 SHALL have port s_valid, input, 1, byte-stream valid.
REQ-009 SHALL have port s_data, input, 8, byte-stream data.
REQ-010 SHALL have port s_ready, output, 1, byte-stream ready.
REQ-011 SHALL have port data_e_para, output, 1, parameter word strobe to the layer-7 loader.
REQ-012 SHALL have port para_in, output signed, `PARA_WIDTH, parameter word to the layer-7 loader.
REQ-013 SHALL have port busy, output, 1, HIGH while in RECV.
REQ-014 SHALL have port load_done, output, 1, HIGH while in DONE.
REQ-015 SHALL have port err_abort, output, 1, sticky flag for a session aborted by mode.
REQ-016 SHALL have port chk_err, output, 1, sticky checksum-mismatch flag.

Function
REQ-017 SHALL require `PARA_WIDTH to be a multiple of 8; BPW = `PARA_WIDTH/8 bytes per word.
REQ-018 SHALL implement FSM IDLE, RECV, DONE (plus CHK when the Configuration feature is compiled in).
REQ-019 IDLE: start=1 and mode=LOW SHALL clear the byte counter, word counter, err_abort and chk_err, and go to RECV; start while mode=HIGH SHALL be ignored.
REQ-020 s_ready SHALL be registered, and HIGH only in RECV and CHK.
REQ-021 A byte SHALL be accepted only on a cycle with s_valid=1 and s_ready=1; first byte is the MSB of the word (big-endian).
REQ-022 Acceptance of byte BPW-1 SHALL assert data_e_para for exactly one cycle on the next cycle, with para_in holding the assembled word; latency is 1 cycle.
REQ-023 para_in SHALL hold its last value when data_e_para=0.
REQ-024 Gaps of any length in s_valid SHALL stall assembly without loss or duplication.
REQ-025 The word counter SHALL increment per emitted word; acceptance of the last byte of word TOTAL-1 SHALL go to DONE (or CHK), so s_ready is LOW on the following cycle.
REQ-026 Word strobes SHALL total exactly TOTAL per session; the counter SHALL never wrap.
REQ-027 DONE SHALL hold load_done=1; mode going HIGH SHALL go to IDLE; start with mode=LOW SHALL restart the session per REQ-019.
REQ-028 In RECV/CHK, mode going HIGH SHALL go to IDLE on the next cycle, set err_abort, discard any partial word, and suppress any pending strobe.
REQ-029 data_e_para SHALL never be HIGH on a cycle where mode is HIGH.

Reset
REQ-030 With rst_n=0 at a rising edge, the block SHALL enter IDLE with all counters 0, s_ready=0, data_e_para=0, para_in=0, busy=0, load_done=0, err_abort=0 and chk_err=0, mid-session included.

Configuration
REQ-031 With macro PARA_CHECKSUM_EN defined: after word TOTAL-1, the FSM SHALL enter CHK and receive one extra BPW-byte word, not forwarded and with no strobe; mismatch against the sum of all TOTAL words mod 2^`PARA_WIDTH SHALL set chk_err; the FSM then goes to DONE.
REQ-032 Without PARA_CHECKSUM_EN: there SHALL be no CHK state and chk_err SHALL be tied 0.

Verification (`PARA_WIDTH=16, defaults)
REQ-033 Reset, start with mode=0, stream 5632 bytes with s_valid held HIGH -> 2816 strobes; first para_in equals first two bytes MSB-first (0x12,0x34 -> 0x1234); load_done=1 afterwards.
REQ-034 Random s_valid gaps of 0-5 cycles -> identical word sequence and strobe count as REQ-033.
REQ-035 mode goes to 1 after 301 bytes -> no strobe for the partial word, err_abort=1, busy=0; the next start clears err_abort.
REQ-036 rst_n=0 for 1 cycle mid-word 1000 -> all outputs reach reset values on the next edge; no further strobe.
REQ-037 PARA_CHECKSUM_EN defined, correct checksum -> chk_err=0; checksum off by 1 -> chk_err=1, 2816 strobes, load_done=1.
REQ-038 start pulsed with mode=1 -> FSM stays in IDLE, s_ready=0.
